el2_bht_ghr_ctl: RTL

//  Maintains speculative and retired global history registers (GHR) for the BHT.

---
 rtl/el2_bht_ghr_ctl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/el2_bht_ghr_ctl.sv
// el2_bht_ghr_ctl: speculative and retired global history registers for the BHT.
// Each accepted prediction checkpoints the pre-update GHR in an in-order FIFO.
// A mispredict rebuilds history from the oldest checkpoint. A flush restores the
// retired history.
// Optional feature macro: EL2_GHR_MISP_STATS_EN adds a saturating mispredict
// counter output (misp_cnt).
module el2_bht_ghr_ctl #(
  parameter int GHR_SIZE   = 8,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                pred_valid,
  input  logic                pred_taken,
  input  logic                res_valid,
  input  logic                res_taken,
  input  logic                res_mispred,
  input  logic                flush,
  output logic [GHR_SIZE-1:0] ghr,
  output logic [GHR_SIZE-1:0] ghr_ret,
  output logic                ckpt_full,
  output logic                ckpt_err
`ifdef EL2_GHR_MISP_STATS_EN
  ,
  output logic [15:0]         misp_cnt
`endif
);

  localparam int PTR_W = $clog2(CKPT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [GHR_SIZE-1:0] ghr_q, ghr_d;
  logic [GHR_SIZE-1:0] ret_q, ret_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [GHR_SIZE-1:0] ckpt_q [CKPT_DEPTH];

  logic fifo_empty, fifo_full;
  logic misp_acc, pop, push, err_set;
  logic [GHR_SIZE-1:0] head_val;

  function automatic logic [GHR_SIZE-1:0] shift_in(input logic [GHR_SIZE-1:0] h,
                                                   input logic                b);
    return {h[GHR_SIZE-2:0], b};
  endfunction

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(CKPT_DEPTH));
  assign head_val   = ckpt_q[head_q];

  // A flush overrides everything; an accepted mispredict overrides pred and resolve.
  // A pred is still accepted when full if a correct resolve frees a slot that cycle.
  assign misp_acc = ~flush & res_valid & res_mispred & ~fifo_empty;
  assign pop      = ~flush & res_valid & ~res_mispred & ~fifo_empty;
  assign push     = ~flush & ~misp_acc & pred_valid & (~fifo_full | pop);
  assign err_set  = ~flush & ((pred_valid & ~misp_acc & ~push) |
                              (res_valid & fifo_empty & ~push));

  // Next-state for history, pointers, occupancy and the sticky error flag
  always_comb begin
    ghr_d  = ghr_q;
    ret_d  = ret_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    err_d  = err_q | err_set;
    if (flush) begin
      ghr_d  = ret_q;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else if (misp_acc) begin
      ghr_d  = shift_in(head_val, res_taken);
      ret_d  = shift_in(head_val, res_taken);
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        ghr_d  = shift_in(ghr_q, pred_taken);
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        ret_d  = shift_in(ret_q, res_taken);
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control and history state with asynchronous reset
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ghr_q  <= '0;
      ret_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ghr_q  <= ghr_d;
      ret_q  <= ret_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Checkpoint storage: payload only, validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) ckpt_q[tail_q] <= ghr_q;
  end

  assign ghr       = ghr_q;
  assign ghr_ret   = ret_q;
  assign ckpt_full = fifo_full;
  assign ckpt_err  = err_q;

`ifdef EL2_GHR_MISP_STATS_EN
  logic [15:0] misp_cnt_q, misp_cnt_d;

  assign misp_cnt_d = (misp_acc && (misp_cnt_q != 16'hFFFF)) ? misp_cnt_q + 16'd1
                                                              : misp_cnt_q;

  // Saturating count of accepted mispredict recoveries; flush does not touch it
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) misp_cnt_q <= '0;
    else        misp_cnt_q <= misp_cnt_d;
  end

  assign misp_cnt = misp_cnt_q;
`endif

endmodule
